// File: rtl/router_pkt_tx_if.sv
// Bus bundle for router_pkt_tx: packet request, load port and router input bus.
// Optional port tx_bad_par exists only when ROUTER_TX_PARITY_INJ_EN is defined.
interface router_pkt_tx_if;
    // Packet request
    logic       tx_start;
    logic [1:0] tx_addr;
    logic [5:0] tx_len;
    logic       tx_ready;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic       tx_bad_par;
`endif
    // Payload load port
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    // Router input bus and status
    logic       busy;
    logic       err;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       err_flag;
    logic [7:0] pkt_count;

    // Transmitter side
    modport master (
        input  tx_start,
        input  tx_addr,
        input  tx_len,
        output tx_ready,
`ifdef ROUTER_TX_PARITY_INJ_EN
        input  tx_bad_par,
`endif
        input  ld_valid,
        input  ld_data,
        output ld_ready,
        input  busy,
        input  err,
        output data_out,
        output pkt_valid,
        output err_flag,
        output pkt_count
    );

    // Traffic source / router side
    modport slave (
        output tx_start,
        output tx_addr,
        output tx_len,
        input  tx_ready,
`ifdef ROUTER_TX_PARITY_INJ_EN
        output tx_bad_par,
`endif
        output ld_valid,
        output ld_data,
        input  ld_ready,
        output busy,
        output err,
        input  data_out,
        input  pkt_valid,
        input  err_flag,
        input  pkt_count
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 1x3 router input port.
// Buffers a payload from the load port, then sends header, payload and parity
// under the pkt_valid/busy protocol, watches err for ERR_WAIT cycles and counts
// completed packets. Define ROUTER_TX_PARITY_INJ_EN to enable deliberate parity
// corruption through tx_bad_par.
module router_pkt_tx #(
    parameter int unsigned ERR_WAIT = 4
) (
    input  logic            clock,
    input  logic            resetn,
    router_pkt_tx_if.master bus
);

    localparam int unsigned CntW = (ERR_WAIT > 1) ? $clog2(ERR_WAIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(ERR_WAIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHeader,
        StPayload,
        StParity,
        StErrw
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      addr_q, addr_d;
    logic [5:0]      len_q, len_d;
    logic [5:0]      wptr_q, wptr_d;
    logic [5:0]      rptr_q, rptr_d;
    logic [7:0]      parity_q, parity_d;
    logic [CntW-1:0] errw_cnt_q, errw_cnt_d;
    logic [7:0]      data_out_q, data_out_d;
    logic            pkt_valid_q, pkt_valid_d;
    logic            ld_ready_q, ld_ready_d;
    logic            tx_ready_q, tx_ready_d;
    logic            err_flag_q, err_flag_d;
    logic [7:0]      pkt_count_q, pkt_count_d;
`ifdef ROUTER_TX_PARITY_INJ_EN
    logic            bad_par_q, bad_par_d;
`endif

    logic [7:0]      mem_q [64];
    logic            mem_we;
    logic            start_ok;
    logic [7:0]      par_out;

    // Only well-formed requests start a packet; the rest are silently dropped.
    assign start_ok = bus.tx_start && (bus.tx_len != 6'd0) && (bus.tx_addr != 2'd3);

    // Byte placed on the bus in the parity slot.
`ifdef ROUTER_TX_PARITY_INJ_EN
    assign par_out = bad_par_q ? ~parity_q : parity_q;
`else
    assign par_out = parity_q;
`endif

    // Next-state and registered-output decode for the transmit FSM.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        parity_d    = parity_q;
        errw_cnt_d  = errw_cnt_q;
        data_out_d  = data_out_q;
        pkt_valid_d = pkt_valid_q;
        ld_ready_d  = ld_ready_q;
        tx_ready_d  = tx_ready_q;
        err_flag_d  = err_flag_q;
        pkt_count_d = pkt_count_q;
`ifdef ROUTER_TX_PARITY_INJ_EN
        bad_par_d   = bad_par_q;
`endif
        mem_we      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    state_d    = StLoad;
                    addr_d     = bus.tx_addr;
                    len_d      = bus.tx_len;
                    wptr_d     = 6'd0;
                    rptr_d     = 6'd0;
                    // Seed with the header byte so parity covers it.
                    parity_d   = {bus.tx_len, bus.tx_addr};
                    err_flag_d = 1'b0;
                    ld_ready_d = 1'b1;
                    tx_ready_d = 1'b0;
`ifdef ROUTER_TX_PARITY_INJ_EN
                    bad_par_d  = bus.tx_bad_par;
`endif
                end
            end

            StLoad: begin
                if (bus.ld_valid && ld_ready_q) begin
                    mem_we   = 1'b1;
                    wptr_d   = wptr_q + 6'd1;
                    parity_d = parity_q ^ bus.ld_data;
                    if (wptr_q == len_q - 6'd1) begin
                        state_d     = StHeader;
                        ld_ready_d  = 1'b0;
                        data_out_d  = {len_q, addr_q};
                        pkt_valid_d = 1'b1;
                    end
                end
            end

            StHeader: begin
                if (!bus.busy) begin
                    state_d    = StPayload;
                    data_out_d = mem_q[rptr_q];
                    rptr_d     = rptr_q + 6'd1;
                end
            end

            StPayload: begin
                if (!bus.busy) begin
                    // rptr counts bytes already put on the bus.
                    if (rptr_q == len_q) begin
                        state_d     = StParity;
                        data_out_d  = par_out;
                        pkt_valid_d = 1'b0;
                    end else begin
                        data_out_d = mem_q[rptr_q];
                        rptr_d     = rptr_q + 6'd1;
                    end
                end
            end

            StParity: begin
                if (bus.err) begin
                    err_flag_d = 1'b1;
                end
                if (!bus.busy) begin
                    state_d    = StErrw;
                    errw_cnt_d = '0;
                    data_out_d = 8'h00;
                end
            end

            StErrw: begin
                if (bus.err) begin
                    err_flag_d = 1'b1;
                end
                if (errw_cnt_q == CntLast) begin
                    state_d     = StIdle;
                    tx_ready_d  = 1'b1;
                    pkt_count_d = pkt_count_q + 8'd1;
                end else begin
                    errw_cnt_d = errw_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d     = StIdle;
                pkt_valid_d = 1'b0;
                ld_ready_d  = 1'b0;
                tx_ready_d  = 1'b1;
            end
        endcase
    end

    // FSM state and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            addr_q      <= 2'd0;
            len_q       <= 6'd0;
            wptr_q      <= 6'd0;
            rptr_q      <= 6'd0;
            parity_q    <= 8'h00;
            errw_cnt_q  <= '0;
            data_out_q  <= 8'h00;
            pkt_valid_q <= 1'b0;
            ld_ready_q  <= 1'b0;
            tx_ready_q  <= 1'b1;
            err_flag_q  <= 1'b0;
            pkt_count_q <= 8'h00;
`ifdef ROUTER_TX_PARITY_INJ_EN
            bad_par_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            parity_q    <= parity_d;
            errw_cnt_q  <= errw_cnt_d;
            data_out_q  <= data_out_d;
            pkt_valid_q <= pkt_valid_d;
            ld_ready_q  <= ld_ready_d;
            tx_ready_q  <= tx_ready_d;
            err_flag_q  <= err_flag_d;
            pkt_count_q <= pkt_count_d;
`ifdef ROUTER_TX_PARITY_INJ_EN
            bad_par_q   <= bad_par_d;
`endif
        end
    end

    // Payload buffer; contents need no reset since pointers restart per packet.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[wptr_q] <= bus.ld_data;
        end
    end

    assign bus.data_out  = data_out_q;
    assign bus.pkt_valid = pkt_valid_q;
    assign bus.ld_ready  = ld_ready_q;
    assign bus.tx_ready  = tx_ready_q;
    assign bus.err_flag  = err_flag_q;
    assign bus.pkt_count = pkt_count_q;

endmodule
